// File: rtl/cmd_proc.sv
// cmd_proc: executes 16-bit commands (WRITE / READ / PING / NAK) against a
// 16x8 register file and hands a one-byte response to the transmitter.
// Optional response-wait timeout: define CMD_PROC_TIMEOUT_EN to enable it.
// Without the macro, the FSM waits in WAIT until resp_sent arrives and
// err_timeout is held at 0.
module cmd_proc #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic [7:0]  resp,
  input  logic        resp_sent,
  output logic        cfg_wr,
  output logic [3:0]  cfg_addr,
  output logic [7:0]  cfg_data,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_PING  = 4'h3;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_PING = 8'h5A;
  localparam logic [7:0] RESP_NAK  = 8'hEE;

  // Reject timeout limits outside the supported 16-bit range at elaboration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cmd_proc: TIMEOUT_CYCLES must be in [2, 65535]");
  end

  state_t      state_q;
  logic [15:0] cmd_q;
  logic [7:0]  regfile_q [16];
  logic        clr_cmd_rdy_q;
  logic        send_resp_q;
  logic [7:0]  resp_q;
  logic        cfg_wr_q;
  logic [3:0]  cfg_addr_q;
  logic [7:0]  cfg_data_q;
  logic        busy_q;
  logic        err_timeout_q;

`ifdef CMD_PROC_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tcnt_q;
`endif

  logic [3:0] op;
  logic [3:0] addr;
  logic [7:0] data;
  logic [7:0] resp_d;
  logic       is_write_d;

  // Decode the captured command into its response byte and write enable.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    op         = cmd_q[15:12];
    addr       = cmd_q[11:8];
    data       = cmd_q[7:0];
    resp_d     = RESP_NAK;
    is_write_d = 1'b0;
    case (op)
      OP_WRITE: begin
        resp_d     = RESP_ACK;
        is_write_d = 1'b1;
      end
      OP_READ:  resp_d = regfile_q[addr];
      OP_PING:  resp_d = RESP_PING;
      default:  resp_d = RESP_NAK;
    endcase
  end

  // Command FSM with registered pulse outputs and the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      clr_cmd_rdy_q <= 1'b0;
      send_resp_q   <= 1'b0;
      resp_q        <= '0;
      cfg_wr_q      <= 1'b0;
      cfg_addr_q    <= '0;
      cfg_data_q    <= '0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      // NOTE: the register file must read 0x00 after reset, so it is built
      // from resettable flops rather than a RAM macro without reset.
      for (int i = 0; i < 16; i++) begin
        regfile_q[i] <= '0;
      end
`ifdef CMD_PROC_TIMEOUT_EN
      tcnt_q        <= '0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // right-hand side sees the pre-edge value regardless of statement order.
      clr_cmd_rdy_q <= 1'b0;
      send_resp_q   <= 1'b0;
      cfg_wr_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_rdy) begin
            cmd_q         <= cmd;
            clr_cmd_rdy_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_q      <= resp_d;
          send_resp_q <= 1'b1;
          if (is_write_d) begin
            regfile_q[addr] <= data;
            cfg_addr_q      <= addr;
            cfg_data_q      <= data;
            cfg_wr_q        <= 1'b1;
          end
          state_q <= ST_SEND;
        end
        ST_SEND: begin
`ifdef CMD_PROC_TIMEOUT_EN
          tcnt_q  <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (resp_sent) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
`ifdef CMD_PROC_TIMEOUT_EN
          end else if (tcnt_q == TIMEOUT_LAST) begin
            // Limit reached with no completion: give up on this response.
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
`endif
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign clr_cmd_rdy = clr_cmd_rdy_q;
  assign send_resp   = send_resp_q;
  assign resp        = resp_q;
  assign cfg_wr      = cfg_wr_q;
  assign cfg_addr    = cfg_addr_q;
  assign cfg_data    = cfg_data_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: doc/cmd_proc.md
CMD_PROC -- requirements
Module: cmd_proc

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, response-wait limit in clk cycles (16-bit range, min 2); used only when CMD_PROC_TIMEOUT_EN is defined.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd  input  16  command word from the UART command receiver: [15:12] opcode, [11:8] address, [7:0] data.
REQ-005 cmd_rdy  input  1  high while cmd holds a complete, unconsumed command.
REQ-006 clr_cmd_rdy  output  1  registered one-cycle pulse acknowledging consumption of cmd.
REQ-007 send_resp  output  1  registered one-cycle pulse requesting transmission of resp.
REQ-008 resp  output  8  response byte; stable from send_resp pulse until resp_sent or timeout.
REQ-009 resp_sent  input  1  one-cycle pulse from transmitter: byte fully sent.
REQ-010 cfg_wr  output  1  registered one-cycle pulse on each register write.
REQ-011 cfg_addr  output  4  address of last write; cfg_data  output  8  data of last write.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 err_timeout  output  1  one-cycle pulse on response timeout.

Function
REQ-014 Internal 16x8 register file, written only by WRITE commands.
REQ-015 FSM states: IDLE, EXEC, SEND, WAIT; one-hot or binary encoding at implementer's choice.
REQ-016 IDLE: on edge with cmd_rdy=1 -> capture cmd into internal cmd_q, clr_cmd_rdy=1 for the following cycle, go EXEC; else stay.
REQ-017 EXEC (exactly one cycle): decode cmd_q, load resp, go SEND.
REQ-018 Opcode 0x1 WRITE: regfile[addr]<=data, cfg_addr/cfg_data<=addr/data, cfg_wr=1 for one cycle (concurrent with SEND state), resp=0xA5.
REQ-019 Opcode 0x2 READ: resp=regfile[addr] (value before any write in same EXEC; none possible).
REQ-020 Opcode 0x3 PING: resp=0x5A; no register change.
REQ-021 Any other opcode (incl. 0x0): resp=0xEE (NAK); no register change, no cfg_wr.
REQ-022 SEND: send_resp=1 for exactly this cycle, go WAIT.
REQ-023 WAIT: on resp_sent=1 -> IDLE; otherwise stay (see Configuration).
REQ-024 Latency: send_resp high exactly 2 cycles after the capture edge; clr_cmd_rdy high exactly 1 cycle after it.
REQ-025 cmd_rdy asserted while busy: ignored, not cleared; serviced on first IDLE cycle.
REQ-026 cmd_rdy high on the same edge WAIT exits to IDLE: not captured that edge; captured next edge.
REQ-027 resp_sent outside WAIT: ignored.
REQ-028 cmd changes after capture have no effect on the executing command.
REQ-029 Back-to-back commands: no command lost or executed twice given upstream clears cmd_rdy within 1 cycle of clr_cmd_rdy.

Reset
REQ-030 rst=1 asynchronously forces: state IDLE, clr_cmd_rdy=0, send_resp=0, resp=0x00, cfg_wr=0, cfg_addr=0, cfg_data=0x00, busy=0, err_timeout=0, cmd_q=0, all regfile entries 0x00, timeout counter 0.
REQ-031 Reset mid-command aborts it; no pending pulse is emitted after rst deasserts.

Configuration
REQ-032 Macro CMD_PROC_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle; if it reaches TIMEOUT_CYCLES without resp_sent -> IDLE, err_timeout=1 for one cycle; resp_sent on the limit cycle takes priority (no error).
REQ-033 Macro undefined: no counter logic, WAIT holds indefinitely, err_timeout tied 0.

Verification
REQ-034 After reset, cmd=0x13C4, cmd_rdy pulse -> clr_cmd_rdy at +1, cfg_wr/cfg_addr=0x3/cfg_data=0xC4 and send_resp with resp=0xA5 at +2.
REQ-035 Then cmd=0x2300 -> resp=0xC4; cmd=0x2700 -> resp=0x00.
REQ-036 cmd=0x3000 -> resp=0x5A; cmd=0xF123 -> resp=0xEE, no cfg_wr, regfile unchanged.
REQ-037 cmd_rdy raised during WAIT, resp_sent 10 cycles later -> command captured one cycle after WAIT exits, executed once.
REQ-038 With CMD_PROC_TIMEOUT_EN, TIMEOUT_CYCLES=8, no resp_sent -> err_timeout pulse 8 cycles after WAIT entry, busy falls; without macro busy stays high 100+ cycles.
REQ-039 rst asserted in EXEC of a WRITE -> no cfg_wr, no send_resp, regfile all 0x00 after release.
